// File: rtl/dlt_bank_pkg.sv
// Shared definitions for the gated/set-reset storage bank and its readback engine.
// Holds the readback FSM encoding, the LATCH_MODE constants and an index-width helper.
package dlt_bank_pkg;

  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_SNAP  = 2'd1,
    RB_SHIFT = 2'd2
  } rb_state_e;

  localparam int LATCH_EDGE        = 0;
  localparam int LATCH_TRANSPARENT = 1;

  // A single channel still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dlt_bank_cell.sv
// One storage channel: per-channel gate/SR polarity, set/reset forcing a constant word,
// and either a registered output or a transparent-latch style output.
module dlt_bank_cell
  import dlt_bank_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter int   LATCH_MODE = LATCH_EDGE,
  parameter logic G_INV      = 1'b0,
  parameter logic SR_INV     = 1'b0,
  parameter logic SR_VAL     = 1'b0,
  parameter logic INIT       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_g,
  input  logic             i_sr,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_s
);

  localparam logic [WIDTH-1:0] SR_WORD   = {WIDTH{SR_VAL}};
  localparam logic [WIDTH-1:0] INIT_WORD = {WIDTH{INIT}};

  logic             w_ge;
  logic             w_se;
  logic [WIDTH-1:0] r_s;

  assign w_ge = i_g ^ G_INV;
  assign w_se = i_sr ^ SR_INV;

  // Reset wins over set/reset, which wins over the gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= INIT_WORD;
    end else if (w_se) begin
      r_s <= SR_WORD;
    end else if (w_ge) begin
      r_s <= i_d;
    end
  end

  assign o_s = r_s;

  generate
    if (LATCH_MODE == LATCH_TRANSPARENT) begin : g_transparent
      // Deliberately independent of rst so q keeps following d during reset.
      assign o_q = w_se ? SR_WORD : (w_ge ? i_d : r_s);
    end else begin : g_edge
      assign o_q = r_s;
    end
  endgenerate

endmodule

// File: rtl/dlt_bank_rb.sv
// Bank of CHANNELS gated storage cells with a snapshot-and-shift readback port
// that streams one channel word per accepted handshake.
module dlt_bank_rb
  import dlt_bank_pkg::*;
#(
  parameter int                  CHANNELS   = 16,
  parameter int                  WIDTH      = 4,
  parameter int                  LATCH_MODE = LATCH_EDGE,
  parameter logic [CHANNELS-1:0] G_INV      = '0,
  parameter logic [CHANNELS-1:0] SR_INV     = '0,
  parameter logic [CHANNELS-1:0] SR_VAL     = '0,
  parameter logic [CHANNELS-1:0] INIT       = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*WIDTH-1:0]           d,
  input  logic [CHANNELS-1:0]                 g,
  input  logic [CHANNELS-1:0]                 sr,
  output logic [CHANNELS*WIDTH-1:0]           q,
  input  logic                                rb_start,
  input  logic                                rb_ready,
  output logic                                rb_valid,
  output logic [WIDTH-1:0]                    rb_data,
  output logic [idx_width(CHANNELS)-1:0]      rb_ch,
  output logic                                rb_busy,
  output logic                                rb_done
);

  localparam int              IW       = idx_width(CHANNELS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(CHANNELS - 1);
  localparam logic [IW-1:0]   ONE_IDX  = IW'(1);

  logic [WIDTH-1:0] w_s [CHANNELS];
  logic [WIDTH-1:0] r_snap [CHANNELS];
  logic [IW-1:0]    w_idx_next;

  rb_state_e        r_state;
  logic [IW-1:0]    r_idx;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_data;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_cell
      dlt_bank_cell #(
        .WIDTH      (WIDTH),
        .LATCH_MODE (LATCH_MODE),
        .G_INV      (G_INV[gi]),
        .SR_INV     (SR_INV[gi]),
        .SR_VAL     (SR_VAL[gi]),
        .INIT       (INIT[gi])
      ) u_cell (
        .clk  (clk),
        .rst  (rst),
        .i_d  (d[gi*WIDTH +: WIDTH]),
        .i_g  (g[gi]),
        .i_sr (sr[gi]),
        .o_q  (q[gi*WIDTH +: WIDTH]),
        .o_s  (w_s[gi])
      );
    end
  endgenerate

  assign w_idx_next = r_idx + ONE_IDX;

  // rb_data is preloaded from the snapshot so every readback output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RB_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_snap[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RB_IDLE: begin
          if (rb_start) begin
            r_state <= RB_SNAP;
            r_busy  <= 1'b1;
          end
        end
        RB_SNAP: begin
          for (int c = 0; c < CHANNELS; c++) begin
            r_snap[c] <= w_s[c];
          end
          r_idx   <= '0;
          r_data  <= w_s[0];
          r_valid <= 1'b1;
          r_state <= RB_SHIFT;
        end
        RB_SHIFT: begin
          if (r_valid && rb_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= RB_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
              r_data  <= '0;
            end else begin
              r_idx  <= w_idx_next;
              r_data <= r_snap[w_idx_next];
            end
          end
        end
        default: begin
          r_state <= RB_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rb_valid = r_valid;
  assign rb_data  = r_data;
  assign rb_ch    = r_idx;
  assign rb_busy  = r_busy;
  assign rb_done  = r_done;

endmodule

// File: doc/dlt_bank_rb.md
DLT_BANK_RB -- requirements
Module: dlt_bank_rb

Interface
REQ-001 SHALL have parameter CHANNELS, default 16, number of storage channels (2..64).
REQ-002 SHALL have parameter WIDTH, default 4, data bits per channel (1..32).
REQ-003 SHALL have parameter LATCH_MODE, default 0: 0 = edge-capture; 1 = transparent output while the gate is open.
REQ-004 SHALL have parameter G_INV, default 0, [CHANNELS-1:0] per-channel gate inversion mask.
REQ-005 SHALL have parameter SR_INV, default 0, [CHANNELS-1:0] per-channel set/reset inversion mask.
REQ-006 SHALL have parameter SR_VAL, default 0, [CHANNELS-1:0] per-channel value forced by SR, replicated across WIDTH.
REQ-007 SHALL have parameter INIT, default 0, [CHANNELS-1:0] per-channel value loaded on rst, replicated across WIDTH.
REQ-008 SHALL have port clk, input, 1 bit: the only clock.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port d, input, CHANNELS*WIDTH bits: channel c occupies d[c*WIDTH +: WIDTH].
REQ-011 SHALL have port g, input, CHANNELS bits: raw per-channel gate.
REQ-012 SHALL have port sr, input, CHANNELS bits: raw per-channel set/reset.
REQ-013 SHALL have port q, output, CHANNELS*WIDTH bits: channel outputs, same packing as d.
REQ-014 SHALL have port rb_start, input, 1 bit: readback request.
REQ-015 SHALL have port rb_ready, input, 1 bit: consumer accepts a readback word.
REQ-016 SHALL have port rb_valid, output, 1 bit: rb_data and rb_ch are valid.
REQ-017 SHALL have port rb_data, output, WIDTH bits: snapshotted channel value.
REQ-018 SHALL have port rb_ch, output, max(1,$clog2(CHANNELS)) bits: index of the channel on rb_data.
REQ-019 SHALL have port rb_busy, output, 1 bit: high in the SNAP and SHIFT states.
REQ-020 SHALL have port rb_done, output, 1 bit: one-cycle pulse after the last word is accepted.

Function
REQ-021 SHALL compute the effective gate ge[c] = g[c] ^ G_INV[c] and effective set/reset se[c] = sr[c] ^ SR_INV[c].
REQ-022 SHALL update stored value s[c] at each clk edge with priority: se[c] loads {WIDTH{SR_VAL[c]}}; else ge[c] loads d[c]; else s[c] holds.
REQ-023 SHALL, with LATCH_MODE=0, drive q[c] = s[c], giving 1-cycle latency from d to q.
REQ-024 SHALL, with LATCH_MODE=1, drive q[c] combinationally: se[c] gives SR_VAL replicated; else ge[c] gives d[c]; else s[c].
REQ-025 SHALL implement the readback FSM with states IDLE, SNAP and SHIFT.
REQ-026 SHALL, in IDLE with rb_start=1, go to SNAP; rb_start in any other state is ignored.
REQ-027 SHALL, in SNAP, copy every s[c] into a snapshot register (one cycle), clear the index to 0, and go to SHIFT.
REQ-028 SHALL, in SHIFT, hold rb_valid=1 with rb_data = snapshot[idx] and rb_ch = idx, stable until rb_valid && rb_ready.
REQ-029 SHALL, on acceptance with idx < CHANNELS-1, increment idx; with idx = CHANNELS-1, return to IDLE and pulse rb_done.
REQ-030 SHALL keep readback data isolated from writes to channels after SNAP.
REQ-031 SHALL allow back-to-back acceptance (rb_ready held at 1): one word per cycle, CHANNELS cycles total.

Reset
REQ-032 SHALL, with rst=1 at a clk edge, set s[c] = {WIDTH{INIT[c]}}; rst overrides se and ge.
REQ-033 SHALL, with rst=1 at a clk edge, force the FSM to IDLE with rb_valid=0, rb_busy=0, rb_done=0, idx=0, rb_data=0 and the snapshot at 0, including mid-readback.
REQ-034 SHALL leave LATCH_MODE=1 combinational paths active during rst, so q can follow d while rst is high.

Structure
REQ-035 SHALL place the FSM state encoding and the LATCH_MODE constants in shared package dlt_bank_pkg.
REQ-036 SHALL instantiate sub-module dlt_bank_cell, one per channel, parameterised by WIDTH, LATCH_MODE and its mask bits.

Verification
REQ-037 SHALL cover reset values: CHANNELS=4, WIDTH=4, INIT=4'b1010, rst pulse -> q = 16'hF0F0, rb_busy=0.
REQ-038 SHALL cover gate inversion: G_INV=4'b0001, g=0, d=16'h1234, one edge -> q[3:0]=4, the other channels keep their INIT values.
REQ-039 SHALL cover SR priority: SR_INV=0, SR_VAL=4'b0100, sr=4'b0100, ge=1 on all channels, d=0 -> q[11:8]=4'hF.
REQ-040 SHALL cover latch mode: LATCH_MODE=1, ge[1]=1, d[7:4] toggling 3->9 mid-cycle -> q[7:4] follows in the same cycle, then holds 9 after the gate closes.
REQ-041 SHALL cover readback: snapshot of q=16'hBEEF, d changed after SNAP, rb_ready stalls on channel 1 for 3 cycles -> words F,E,E,B with rb_ch 0..3, then rb_done for 1 cycle.
REQ-042 SHALL cover reset mid-readback: rst during SHIFT with idx=2 -> next cycle rb_valid=0, IDLE; a new rb_start restarts at rb_ch=0.
